// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag struct and flag-ownership helper for the ALU writeback path
package alu_pkg;

   localparam logic [3:0] OP_SUB  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_MAX  = 4'd3;
   localparam logic [3:0] OP_SLT  = 4'd4;
   localparam logic [3:0] OP_SLTU = 4'd5;

   typedef struct packed {
      logic carry;
      logic zero;
      logic overflow;
   } alu_flags_t;

   // Only the adder-based opcodes drive meaningful carry/overflow.
   function automatic logic has_arith_flags(input logic [3:0] opcode);
      return (opcode == OP_SUB) || (opcode == OP_ADD);
   endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - register-based circular FIFO with pointers and occupancy count
// Storage resets to zero so the read port never shows X, even when empty.
module alu_result_fifo #(
   parameter int DATA_W = 72,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [DATA_W-1:0]          rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              push, pop;

   // Full blocks a push even when a pop happens the same cycle.
   assign wr_ready = (count_q != FULL_CNT);
   assign rd_valid = (count_q != '0);
   assign rd_data  = mem_q[rd_ptr_q];
   assign count    = count_q;

   always_comb begin
      push     = wr_valid && wr_ready;
      pop      = rd_ready && rd_valid;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - flag-sanitising ALU result queue feeding register-file writeback
// Optional sticky carry/overflow status via ALU_RESULT_STICKY_EN.
module alu_result_buffer
   import alu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 in_opcode,
   input  logic [WIDTH-1:0]           in_result,
   input  logic                       in_carry,
   input  logic                       in_overflow,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_result,
   output logic                       out_carry,
   output logic                       out_zero,
   output logic                       out_overflow,
   output logic [TAG_W-1:0]           out_tag,
`ifdef ALU_RESULT_STICKY_EN
   input  logic                       sticky_clr,
   output logic                       sticky_carry,
   output logic                       sticky_overflow,
`endif
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int ENTRY_W = WIDTH + 3 + TAG_W;

   alu_flags_t         in_flags;
   alu_flags_t         out_flags;
   logic [ENTRY_W-1:0] wr_data;
   logic [ENTRY_W-1:0] rd_data;

   // Upstream zero is ignored; carry/overflow are undriven outside SUB/ADD.
   always_comb begin
      in_flags.zero     = (in_result == '0);
      in_flags.carry    = has_arith_flags(in_opcode) ? in_carry : 1'b0;
      in_flags.overflow = has_arith_flags(in_opcode) ? in_overflow : 1'b0;
      wr_data           = {in_result, in_flags, in_tag};
   end

   alu_result_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (in_valid),
      .wr_ready (in_ready),
      .wr_data  (wr_data),
      .rd_valid (out_valid),
      .rd_ready (out_ready),
      .rd_data  (rd_data),
      .count    (count)
   );

   assign {out_result, out_flags, out_tag} = rd_data;
   assign out_carry    = out_flags.carry;
   assign out_zero     = out_flags.zero;
   assign out_overflow = out_flags.overflow;

`ifdef ALU_RESULT_STICKY_EN
   logic pop;
   logic sticky_carry_q, sticky_carry_d;
   logic sticky_overflow_q, sticky_overflow_d;

   // A clear coinciding with a pop restarts accumulation from the popped flags.
   always_comb begin
      pop               = out_valid && out_ready;
      sticky_carry_d    = sticky_carry_q;
      sticky_overflow_d = sticky_overflow_q;
      if (pop) begin
         sticky_carry_d    = sticky_clr ? out_carry : (sticky_carry_q | out_carry);
         sticky_overflow_d = sticky_clr ? out_overflow : (sticky_overflow_q | out_overflow);
      end else if (sticky_clr) begin
         sticky_carry_d    = 1'b0;
         sticky_overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_carry_q    <= 1'b0;
         sticky_overflow_q <= 1'b0;
      end else begin
         sticky_carry_q    <= sticky_carry_d;
         sticky_overflow_q <= sticky_overflow_d;
      end
   end

   assign sticky_carry    = sticky_carry_q;
   assign sticky_overflow = sticky_overflow_q;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - scoreboard bench for alu_result_buffer (sticky checks under ALU_RESULT_STICKY_EN)
module tb_alu_result_buffer;

   localparam int WIDTH = 64;
   localparam int DEPTH = 4;
   localparam int TAG_W = 5;

   typedef struct {
      logic [WIDTH-1:0] r;
      logic             c;
      logic             z;
      logic             o;
      logic [TAG_W-1:0] t;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       in_opcode = '0;
   logic [WIDTH-1:0] in_result = '0;
   logic             in_carry = 1'b0;
   logic             in_overflow = 1'b0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_result;
   logic             out_carry;
   logic             out_zero;
   logic             out_overflow;
   logic [TAG_W-1:0] out_tag;
   logic [2:0]       count;
`ifdef ALU_RESULT_STICKY_EN
   logic             sticky_clr = 1'b0;
   logic             sticky_carry;
   logic             sticky_overflow;
`endif

   int   n_pass = 0;
   int   n_total = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_opcode    (in_opcode),
      .in_result    (in_result),
      .in_carry     (in_carry),
      .in_overflow  (in_overflow),
      .in_tag       (in_tag),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_carry    (out_carry),
      .out_zero     (out_zero),
      .out_overflow (out_overflow),
      .out_tag      (out_tag),
`ifdef ALU_RESULT_STICKY_EN
      .sticky_clr      (sticky_clr),
      .sticky_carry    (sticky_carry),
      .sticky_overflow (sticky_overflow),
`endif
      .count        (count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Called just after a falling edge; drives one cycle of stimulus and scores it.
   task automatic step(input bit v, input logic [3:0] op, input logic [WIDTH-1:0] res,
                       input bit c, input bit o, input logic [TAG_W-1:0] tag, input bit rdy);
      exp_t e;
      bit   push, pop;
      in_valid    = v;
      in_opcode   = op;
      in_result   = res;
      in_carry    = c;
      in_overflow = o;
      in_tag      = tag;
      out_ready   = rdy;
      #1;
      check("count", 64'(count), 64'(sb.size()));
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      check("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
      push = v && (sb.size() < DEPTH);
      pop  = rdy && (sb.size() > 0);
      if (pop) begin
         e = sb.pop_front();
         check("out_result", out_result, e.r);
         check("out_flags", 64'({out_carry, out_zero, out_overflow}), 64'({e.c, e.z, e.o}));
         check("out_tag", 64'(out_tag), 64'(e.t));
      end
      if (push) begin
         e.r = res;
         e.z = (res == 0);
         e.c = (op == 4'd0 || op == 4'd1) ? c : 1'b0;
         e.o = (op == 4'd0 || op == 4'd1) ? o : 1'b0;
         e.t = tag;
         sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      // reset state
      @(negedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_out_result", out_result, 64'd0);
      check("rst_out_meta", 64'({out_carry, out_zero, out_overflow, out_tag}), 64'd0);
`ifdef ALU_RESULT_STICKY_EN
      check("rst_sticky", 64'({sticky_carry, sticky_overflow}), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // ADD with zero result keeps carry/overflow, zero recomputed
      step(1, 4'd1, 64'h0, 1, 1, 5'd3, 0);
      check("add_latency_valid", 64'(out_valid), 64'd1);
      step(0, 4'd0, 64'h0, 0, 0, 5'd0, 1);

      // AND forces carry/overflow low
      step(1, 4'd2, 64'h5, 1, 1, 5'd7, 0);
      step(0, 4'd0, 64'h0, 0, 0, 5'd0, 1);

      // fill, then refused push with same-cycle pop
      for (int i = 0; i < DEPTH; i++)
         step(1, 4'(i), 64'(100 + i), 1, 1, 5'(i + 10), 0);
      check("full_count", 64'(count), 64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      step(1, 4'd1, 64'hdead, 1, 0, 5'd31, 1);
      check("refused_count", 64'(count), 64'd3);
      for (int i = 0; i < 3; i++)
         step(0, 4'd0, 64'h0, 0, 0, 5'd0, 1);
      check("drained_valid", 64'(out_valid), 64'd0);

      // streaming 1..16, one per cycle, including undefined opcodes
      for (int i = 1; i <= 16; i++) begin
         step(1, 4'(i % 16), 64'(i), i[0], i[1], 5'(i), 1);
         check("stream_valid", 64'(out_valid), 64'd1);
      end
      step(0, 4'd0, 64'h0, 0, 0, 5'd0, 1);

      // reset mid-operation with two entries queued
      step(1, 4'd1, 64'h11, 1, 0, 5'd1, 0);
      step(1, 4'd0, 64'h22, 0, 1, 5'd2, 0);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_count", 64'(count), 64'd0);
      check("midrst_out_result", out_result, 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 4'd9, 64'h33, 1, 1, 5'd4, 0);
      step(0, 4'd0, 64'h0, 0, 0, 5'd0, 1);

`ifdef ALU_RESULT_STICKY_EN
      step(1, 4'd0, 64'h44, 0, 1, 5'd5, 0);
      step(0, 4'd0, 64'h0, 0, 0, 5'd0, 1);
      check("sticky_ovf_set", 64'(sticky_overflow), 64'd1);
      step(1, 4'd1, 64'h55, 0, 0, 5'd6, 0);
      sticky_clr = 1'b1;
      step(0, 4'd0, 64'h0, 0, 0, 5'd0, 1);
      sticky_clr = 1'b0;
      check("sticky_ovf_clr", 64'(sticky_overflow), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Downstream writeback stage for the generated 64-bit ALUs. It captures each combinational ALU result with its opcode and tag, and sanitises the flags per opcode: zero is recomputed, and carry/overflow are forced to 0 where the ALU leaves them undriven. Results are queued in a small FIFO and delivered to the register-file writeback port over a valid/ready handshake. Optional sticky carry/overflow status registers accumulate flags of delivered results.

## Interface
- WIDTH, 64, result datapath width in bits
- DEPTH, 4, FIFO entries; power of two, ≥2
- TAG_W, 5, destination tag width (register index)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset; one clock domain, reset asserted asynchronously
- in_valid  input  1  upstream result valid
- in_ready  output  1  buffer can accept (= !full)
- in_opcode  input  4  ALU opcode: SUB=0, ADD=1, AND=2, MAX=3, SLT=4, SLTU=5
- in_result  input  WIDTH  ALU result
- in_carry  input  1  ALU carry flag
- in_overflow  input  1  ALU overflow flag
- in_tag  input  TAG_W  destination tag
- out_valid  output  1  head entry valid (= !empty)
- out_ready  input  1  consumer accepts head
- out_result  output  WIDTH  head result
- out_carry, out_zero, out_overflow  output  1 each  head flags
- out_tag  output  TAG_W  head tag
- count  output  $clog2(DEPTH+1)  occupancy
- sticky_clr  input  1  clear sticky flags (present only with macro)
- sticky_carry, sticky_overflow  output  1 each  accumulated flags (present only with macro)

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- Flag sanitisation at push:
  - zero = (in_result == 0); the upstream zero flag is not used.
  - carry and overflow pass through for SUB/ADD only and are forced to 0 for all other opcodes, including undefined 6–15.
  - Undefined opcodes store the result unchanged.
- Storage: circular buffer with write pointer, read pointer, and count; pointers wrap modulo DEPTH.
- Full (count==DEPTH): in_ready=0, and a push is refused even if a pop occurs the same cycle. No full-bypass path.
- Empty: out_valid=0. A push into an empty buffer becomes visible on the next cycle; there is no combinational bypass.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- out_* are driven from the head entry; they hold stable while out_valid && !out_ready.
- Outputs for a non-valid head are don't-care, but are driven from storage (no X after reset, since storage resets to 0).

## Timing
- Reset (async assert, sync deassert handled by the top): pointers=0, count=0, in_ready=1, out_valid=0, all out_* data=0, sticky_*=0, storage=0.
- Latency: 1 cycle from push to out_valid. Throughput: 1 result per cycle while neither full nor stalled.
- in_ready and out_valid are registered functions of count; there is no combinational path from in_valid to out_valid or from out_ready to in_ready.
- Reset mid-operation discards all entries immediately; the first post-reset push behaves as into an empty buffer.

## Configuration
- ALU_RESULT_STICKY_EN defined:
  - sticky_clr, sticky_carry, and sticky_overflow exist.
  - On each pop: sticky_x_next = sticky_clr ? popped_x : (sticky_x | popped_x).
  - sticky_clr without a pop clears to 0.
  - Registered; visible the cycle after the pop.
- Undefined: those ports and registers are absent; behaviour is otherwise identical.

## Structure
- Shared package alu_pkg:
  - opcode localparams SUB..SLTU
  - typedef alu_flags_t {carry, zero, overflow}
  - function has_arith_flags(opcode) returning 1 for SUB/ADD
- Sub-module alu_result_fifo: generic DEPTH×(WIDTH+3+TAG_W) register-based FIFO, with pointer and count logic.
- The top instantiates the FIFO, performs sanitisation before the write port, and holds the sticky logic.

## Test plan
- Reset, then push ADD result 0x0, carry=1, ovf=1, tag=3 -> next cycle out_valid=1, out_zero=1, out_carry=1, out_overflow=1, out_tag=3.
- Push AND result 0x5 with in_carry=1, in_overflow=1 -> out_carry=0, out_overflow=0, out_zero=0.
- Push 4 entries with out_ready=0 -> count=4, in_ready=0. A 5th push plus one pop in the same cycle -> 5th refused, count=3.
- Continuous push/pop streaming of results 1..16 with out_ready held 1 -> delivered in order at one per cycle; pointers wrap cleanly.
- Assert rst_n low with 2 entries queued -> out_valid=0, count=0, out_result=0 immediately.
- With ALU_RESULT_STICKY_EN: pop an overflowed SUB -> sticky_overflow=1. Pop with sticky_clr and an entry having ovf=0 -> sticky_overflow=0.
